// File: rtl/layer_three.sv
// Final dense classifier stage: XNOR-popcount of the latched layer-2 feature map
// against binary weights for 10 classes, reporting the argmax digit.
module layer_three (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [2:0]    state,
   input  logic [195:0]  fmap,
   input  logic [1959:0] weights,
   output logic [3:0]    digit,
   output logic [7:0]    best_score,
   output logic          done
);

   localparam logic [2:0] S_LAYER_3 = 3'b100;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ACCUM   = 2'd1;
   localparam logic [1:0] S_COMPARE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam logic [3:0] LAST_CLASS = 4'd9;
   localparam logic [2:0] LAST_CHUNK = 3'd6;

   logic          en;
   logic [1:0]    fsm_q, fsm_d;
   logic [3:0]    class_q, class_d;
   logic [2:0]    chunk_q, chunk_d;
   logic [7:0]    acc_q, acc_d;
   logic [195:0]  buf_q, buf_d;
   logic [3:0]    digit_q, digit_d;
   logic [7:0]    best_q, best_d;
   logic          done_q, done_d;

   logic [10:0]   w_base;
   logic [7:0]    f_base;
   logic [27:0]   match;
   logic [4:0]    pop;

   assign en = (state == S_LAYER_3);

   // Chunk offsets within the latched map and within the current class's weight row
   assign w_base = 11'(class_q) * 11'd196 + 11'(chunk_q) * 11'd28;
   assign f_base = 8'(chunk_q) * 8'd28;
   assign match  = ~(buf_q[f_base +: 28] ^ weights[w_base +: 28]);

   always_comb begin
      pop = 5'd0;
      for (int i = 0; i < 28; i++) begin
         pop = pop + {4'd0, match[i]};
      end
   end

   always_comb begin
      fsm_d   = fsm_q;
      class_d = class_q;
      chunk_d = chunk_q;
      acc_d   = acc_q;
      buf_d   = buf_q;
      digit_d = digit_q;
      best_d  = best_q;
      done_d  = done_q;
      if (en) begin
         case (fsm_q)
            S_IDLE: begin
               buf_d   = fmap;
               class_d = 4'd0;
               chunk_d = 3'd0;
               acc_d   = 8'd0;
               fsm_d   = S_ACCUM;
            end
            S_ACCUM: begin
               acc_d = acc_q + {3'd0, pop};
               if (chunk_q == LAST_CHUNK) begin
                  chunk_d = 3'd0;
                  fsm_d   = S_COMPARE;
               end else begin
                  chunk_d = chunk_q + 3'd1;
               end
            end
            S_COMPARE: begin
               // Strict compare keeps the lowest class index on ties
               if (class_q == 4'd0 || acc_q > best_q) begin
                  best_d  = acc_q;
                  digit_d = class_q;
               end
               acc_d = 8'd0;
               if (class_q == LAST_CLASS) begin
                  fsm_d  = S_DONE;
                  done_d = 1'b1;
               end else begin
                  class_d = class_q + 4'd1;
                  fsm_d   = S_ACCUM;
               end
            end
            default: begin
               fsm_d = S_DONE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= S_IDLE;
         class_q <= 4'd0;
         chunk_q <= 3'd0;
         acc_q   <= 8'd0;
         buf_q   <= '0;
         digit_q <= 4'd0;
         best_q  <= 8'd0;
         done_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         class_q <= class_d;
         chunk_q <= chunk_d;
         acc_q   <= acc_d;
         buf_q   <= buf_d;
         digit_q <= digit_d;
         best_q  <= best_d;
         done_q  <= done_d;
      end
   end

   assign digit      = digit_q;
   assign best_score = best_q;
   assign done       = done_q;

endmodule
